// File: rtl/mic_sampler_pkg.sv
// rtl/mic_sampler_pkg.sv - states, register map and status helper; BUTTON_POLL_EN adds the button states
package mic_sampler_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SET_HI,
    WAIT_HI,
    RD_REQ,
    RD_CAP,
    SET_LO,
    WAIT_LO,
    PUSH,
    STAT_WR
`ifdef BUTTON_POLL_EN
    ,
    BTN_RD,
    BTN_CAP
`endif
  } state_e;

  localparam logic [2:0] ADDR_A0     = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_D0     = 3'd2;
  localparam logic [2:0] ADDR_BTN    = 3'd3;

  // Status GPIO word: FIFO level in the low nibble, saturated at 15
  function automatic logic [31:0] status_word(input logic [4:0] count);
    return {28'b0, (count > 5'd15) ? 4'hF : count[3:0]};
  endfunction

endpackage

// File: rtl/mic_sampler_master_if.sv
// rtl/mic_sampler_master_if.sv - Avalon-MM master bus toward the microphone/button peripheral
interface mic_sampler_master_if;
  logic [2:0]  avm_m0_address;
  logic        avm_m0_write;
  logic        avm_m0_read;
  logic [31:0] avm_m0_writedata;
  logic [31:0] avm_m0_readdata;

  modport master (
    output avm_m0_address,
    output avm_m0_write,
    output avm_m0_read,
    output avm_m0_writedata,
    input  avm_m0_readdata
  );

  modport slave (
    input  avm_m0_address,
    input  avm_m0_write,
    input  avm_m0_read,
    input  avm_m0_writedata,
    output avm_m0_readdata
  );
endinterface

// File: rtl/mic_sampler_master_sample_fifo.sv
// rtl/mic_sampler_master_sample_fifo.sv - first-word-fall-through sample FIFO with level output
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         s_tdata_i,
  input  logic                     s_tvalid_i,
  output logic                     s_tready_o,
  output logic [WIDTH-1:0]         m_tdata_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  assign m_tvalid_o = (count_q != '0);
  assign m_tdata_o  = m_tvalid_o ? mem_q[rd_q] : '0;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign s_tready_o = (count_q != CW'(DEPTH)) || m_tready_i;
  assign pop        = m_tvalid_o && m_tready_i;
  assign push       = s_tvalid_i && s_tready_o;
  assign count_o    = count_q;

  // Storage is not reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_tdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end
endmodule

// File: rtl/mic_sampler_master.sv
// rtl/mic_sampler_master.sv - bit-banged microphone sampler master; BUTTON_POLL_EN enables button polling
module mic_sampler_master
  import mic_sampler_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int HALF_PERIOD = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  mic_sampler_master_if.master   avm,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overflow,
  input  logic                   clear_ovf,
  output logic [1:0]             buttons,
  output logic                   btn_change
);
  localparam int BW = $clog2(SAMPLE_BITS);
  localparam int WW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                 state_q;
  logic                   write_q;
  logic                   read_q;
  logic [2:0]             address_q;
  logic [31:0]            writedata_q;
  logic [SAMPLE_BITS-1:0] shift_q;
  logic [BW-1:0]          bitcnt_q;
  logic [WW-1:0]          wait_q;
  logic                   ovf_q;

  logic                   push_valid;
  logic                   fifo_ready;
  logic [CW-1:0]          fifo_count;
  logic                   push_acc;
  logic                   pop;
  logic                   drop;
  logic [CW-1:0]          cnt_d;
  logic                   unused_readdata;

  assign avm.avm_m0_address   = address_q;
  assign avm.avm_m0_write     = write_q;
  assign avm.avm_m0_read      = read_q;
  assign avm.avm_m0_writedata = writedata_q;
  assign unused_readdata      = ^avm.avm_m0_readdata[31:1];

  assign push_valid = (state_q == PUSH);
  assign push_acc   = push_valid && fifo_ready;
  assign drop       = push_valid && !fifo_ready;
  assign pop        = sample_valid && sample_ready;
  assign overflow   = ovf_q;

  // FIFO level as it will stand after this cycle's push/pop, for the status write
  always_comb begin
    cnt_d = fifo_count;
    if (push_acc && !pop)      cnt_d = fifo_count + CW'(1);
    else if (!push_acc && pop) cnt_d = fifo_count - CW'(1);
  end

  // Bus sequencer: strobes are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      wait_q      <= '0;
    end else begin
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      address_q   <= ADDR_A0;
      writedata_q <= '0;
      case (state_q)
        IDLE: if (enable) begin
          state_q     <= SET_HI;
          bitcnt_q    <= BW'(SAMPLE_BITS - 1);
          write_q     <= 1'b1;
          writedata_q <= 32'd1;
        end
        SET_HI: begin
          state_q <= WAIT_HI;
          wait_q  <= WW'(HALF_PERIOD - 1);
        end
        WAIT_HI: if (wait_q == '0) begin
          state_q   <= RD_REQ;
          read_q    <= 1'b1;
          address_q <= ADDR_D0;
        end else begin
          wait_q <= wait_q - WW'(1);
        end
        RD_REQ: state_q <= RD_CAP;
        RD_CAP: begin
          shift_q[bitcnt_q] <= avm.avm_m0_readdata[0];
          state_q           <= SET_LO;
          write_q           <= 1'b1;
        end
        SET_LO: begin
          state_q <= WAIT_LO;
          wait_q  <= WW'(HALF_PERIOD - 1);
        end
        WAIT_LO: if (wait_q == '0) begin
          if (bitcnt_q != '0) begin
            bitcnt_q    <= bitcnt_q - BW'(1);
            state_q     <= SET_HI;
            write_q     <= 1'b1;
            writedata_q <= 32'd1;
          end else begin
            state_q <= PUSH;
          end
        end else begin
          wait_q <= wait_q - WW'(1);
        end
        PUSH: begin
          state_q     <= STAT_WR;
          write_q     <= 1'b1;
          address_q   <= ADDR_STATUS;
          writedata_q <= status_word(5'(cnt_d));
        end
        STAT_WR: begin
`ifdef BUTTON_POLL_EN
          state_q   <= BTN_RD;
          read_q    <= 1'b1;
          address_q <= ADDR_BTN;
`else
          state_q   <= IDLE;
`endif
        end
`ifdef BUTTON_POLL_EN
        BTN_RD:  state_q <= BTN_CAP;
        BTN_CAP: state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as clear_ovf leaves it set
  always_ff @(posedge clk) begin
    if (rst)            ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
    else if (clear_ovf) ovf_q <= 1'b0;
  end

`ifdef BUTTON_POLL_EN
  logic [1:0] buttons_q;
  logic       btn_change_q;

  // Latch the polled buttons and pulse btn_change for one cycle on a new value
  always_ff @(posedge clk) begin
    if (rst) begin
      buttons_q    <= '0;
      btn_change_q <= 1'b0;
    end else begin
      btn_change_q <= 1'b0;
      if (state_q == BTN_CAP) begin
        buttons_q    <= avm.avm_m0_readdata[1:0];
        btn_change_q <= (avm.avm_m0_readdata[1:0] != buttons_q);
      end
    end
  end

  assign buttons    = buttons_q;
  assign btn_change = btn_change_q;
`else
  assign buttons    = 2'b00;
  assign btn_change = 1'b0;
`endif

  sample_fifo #(
    .WIDTH (SAMPLE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .s_tdata_i  (shift_q),
    .s_tvalid_i (push_valid),
    .s_tready_o (fifo_ready),
    .m_tdata_o  (sample_data),
    .m_tvalid_o (sample_valid),
    .m_tready_i (sample_ready),
    .count_o    (fifo_count)
  );
endmodule

// File: tb/tb_mic_sampler_master.sv
// tb/tb_mic_sampler_master.sv - self-checking bench for mic_sampler_master with a peripheral model
module tb_mic_sampler_master;
  localparam int SB = 16;
  localparam int HP = 8;
  localparam int FD = 8;
`ifdef BUTTON_POLL_EN
  localparam int         WORD_PERIOD = 325;
  localparam logic [1:0] EXP_BTN     = 2'd2;
  localparam int         EXP_PULSE   = 1;
`else
  localparam int         WORD_PERIOD = 323;
  localparam logic [1:0] EXP_BTN     = 2'd0;
  localparam int         EXP_PULSE   = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          sample_ready;
  logic          clear_ovf;
  logic [SB-1:0] sample_data;
  logic          sample_valid;
  logic          overflow;
  logic [1:0]    buttons;
  logic          btn_change;

  mic_sampler_master_if bus ();

  mic_sampler_master #(.SAMPLE_BITS(SB), .HALF_PERIOD(HP), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .avm          (bus),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .buttons      (buttons),
    .btn_change   (btn_change)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Peripheral model state
  int unsigned cyc = 0;
  int unsigned last_rise = 0;
  int unsigned rise_cnt = 0;
  int unsigned strobe_cnt = 0;
  int unsigned prot_err = 0;
  int unsigned tim_err = 0;
  int unsigned pulse_cnt = 0;
  logic [31:0] rnd = 32'h0;
  logic        d0 = 1'b0;
  logic [1:0]  btn_val = 2'd0;
  logic        mic_bits[$];
  logic        a0_log[$];
  logic [31:0] status_q[$];
  int unsigned stat_cyc[$];

  // Reference model
  logic [SB-1:0] pending[$];
  logic [SB-1:0] model_fifo[$];
  logic          model_ovf = 1'b0;
  int            stat_done = 0;

  always @(negedge clk) rnd <= $urandom;

  always @(negedge clk) if (btn_change) pulse_cnt <= pulse_cnt + 1;

  // Slave: mic shifts out its next bit on each a0 rise; readdata is garbage except the cycle after a read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.avm_m0_readdata <= rnd;
    if (bus.avm_m0_read && bus.avm_m0_write) prot_err <= prot_err + 1;
    if (!bus.avm_m0_read && !bus.avm_m0_write &&
        (bus.avm_m0_address != 3'd0 || bus.avm_m0_writedata != 32'd0)) prot_err <= prot_err + 1;
    if (bus.avm_m0_read || bus.avm_m0_write) strobe_cnt <= strobe_cnt + 1;
    if (bus.avm_m0_write) begin
      case (bus.avm_m0_address)
        3'd0: begin
          a0_log.push_back(bus.avm_m0_writedata[0]);
          if (bus.avm_m0_writedata[0]) begin
            rise_cnt  <= rise_cnt + 1;
            last_rise <= cyc;
            if (mic_bits.size() > 0) d0 <= mic_bits.pop_front();
            else d0 <= rnd[0];
          end
        end
        3'd1: begin
          status_q.push_back(bus.avm_m0_writedata);
          stat_cyc.push_back(cyc);
        end
        default: prot_err <= prot_err + 1;
      endcase
    end
    if (bus.avm_m0_read) begin
      case (bus.avm_m0_address)
        3'd2: begin
          bus.avm_m0_readdata <= {rnd[31:1], d0};
          if (cyc - last_rise != HP + 1) tim_err <= tim_err + 1;
        end
        3'd3: begin
          bus.avm_m0_readdata <= {rnd[31:2], btn_val};
`ifndef BUTTON_POLL_EN
          prot_err <= prot_err + 1;
`endif
        end
        default: prot_err <= prot_err + 1;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [SB-1:0] w);
    for (int i = SB - 1; i >= 0; i--) mic_bits.push_back(w[i]);
    pending.push_back(w);
  endtask

  // Wait for the next status write, then apply the word to the model FIFO
  task automatic finish_word(input string tag);
    int n;
    logic [SB-1:0] w;
    n = 0;
    while (status_q.size() <= stat_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, 32'(status_q.size() > stat_done), 32'd1);
    if (status_q.size() > stat_done && pending.size() > 0) begin
      w = pending.pop_front();
      if (model_fifo.size() < FD) model_fifo.push_back(w);
      else model_ovf = 1'b1;
      check({tag, " status"}, status_q[stat_done],
            32'((model_fifo.size() > 15) ? 15 : model_fifo.size()));
      stat_done++;
    end
  endtask

  task automatic drain(input string tag, input int n);
    logic [SB-1:0] w;
    @(negedge clk);
    sample_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = (model_fifo.size() > 0) ? model_fifo.pop_front() : '0;
      check({tag, " valid"}, 32'(sample_valid), 32'd1);
      check({tag, " data"}, 32'(sample_data), 32'(w));
      @(negedge clk);
    end
    sample_ready = 1'b0;
    check({tag, " empty"}, 32'(sample_valid), 32'(model_fifo.size() > 0));
  endtask

  task automatic pulse_enable();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " address"}, 32'(bus.avm_m0_address), 32'd0);
    check({tag, " write"}, 32'(bus.avm_m0_write), 32'd0);
    check({tag, " read"}, 32'(bus.avm_m0_read), 32'd0);
    check({tag, " writedata"}, bus.avm_m0_writedata, 32'd0);
    check({tag, " valid"}, 32'(sample_valid), 32'd0);
    check({tag, " data"}, 32'(sample_data), 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
    check({tag, " buttons"}, 32'(buttons), 32'd0);
    check({tag, " btn_change"}, 32'(btn_change), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;
    int unsigned s;
    int alt_err;
    int base;
    int unsigned pb;

    rst = 1'b1;
    enable = 1'b0;
    sample_ready = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single word 0xA5C3, enable pulsed once
    load_word(16'hA5C3);
    base = a0_log.size();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    edges = 1;
    while (!sample_valid && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
    check("valid latency", 32'(edges), 32'd322);
    finish_word("wordA");
    check("wordA a0 writes", 32'(a0_log.size() - base), 32'd32);
    alt_err = 0;
    for (int i = 0; i < 32 && base + i < a0_log.size(); i++)
      if (a0_log[base + i] != ((i % 2) == 0)) alt_err++;
    check("wordA a0 alternate", 32'(alt_err), 32'd0);
    check("wordA head", 32'(sample_data), 32'h0000A5C3);
    repeat (10) @(negedge clk);
    s = strobe_cnt;
    repeat (400) @(negedge clk);
    check("idle after pulse", strobe_cnt - s, 32'd0);
    drain("wordA", 1);

    // Three random words back to back; enable dropped partway through the third
    for (int k = 0; k < 3; k++) load_word(SB'($urandom));
    @(negedge clk);
    enable = 1'b1;
    finish_word("rnd1");
    finish_word("rnd2");
    repeat (60) @(negedge clk);
    enable = 1'b0;
    finish_word("rnd3");
    repeat (10) @(negedge clk);
    s = strobe_cnt;
    repeat (400) @(negedge clk);
    check("stop after drop", strobe_cnt - s, 32'd0);
    drain("rnd", 3);

    // Nine words into a depth-8 FIFO with no consumer
    for (int k = 0; k < 9; k++) load_word(SB'($urandom));
    base = stat_done;
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) finish_word("ovf fill");
    check("word period", stat_cyc[base + 1] - stat_cyc[base], 32'(WORD_PERIOD));
    repeat (50) @(negedge clk);
    enable = 1'b0;
    finish_word("ovf drop");
    check("ovf set", 32'(overflow), 32'(model_ovf));
    check("ovf status 8", status_q[stat_done - 1], 32'd8);
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("ovf cleared", 32'(overflow), 32'd0);
    repeat (10) @(negedge clk);
    drain("ovf", 8);

    // Buttons change mid-word, then stay unchanged for the next word
    pb = pulse_cnt;
    load_word(SB'($urandom));
    pulse_enable();
    repeat (100) @(negedge clk);
    btn_val = 2'd2;
    finish_word("btn1");
    repeat (6) @(negedge clk);
    check("buttons value", 32'(buttons), 32'(EXP_BTN));
    check("btn pulse once", pulse_cnt - pb, 32'(EXP_PULSE));
    pb = pulse_cnt;
    load_word(SB'($urandom));
    pulse_enable();
    finish_word("btn2");
    repeat (6) @(negedge clk);
    check("btn no pulse", pulse_cnt - pb, 32'd0);
    drain("btn", 2);

    // Reset in the middle of a word with one sample already queued
    load_word(SB'($urandom));
    pulse_enable();
    finish_word("pre rst");
    repeat (6) @(negedge clk);
    load_word(SB'($urandom));
    s = rise_cnt;
    enable = 1'b1;
    edges = 0;
    while (rise_cnt < s + 6 && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
    check("reached bit 5", 32'(rise_cnt >= s + 6), 32'd1);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid rst");
    model_fifo.delete();
    pending.delete();
    mic_bits.delete();
    model_ovf = 1'b0;
    stat_done = status_q.size();
    load_word(SB'($urandom));
    pulse_enable();
    finish_word("post rst");
    repeat (6) @(negedge clk);
    drain("post rst", 1);

    check("protocol errors", prot_err, 32'd0);
    check("sample timing errors", tim_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
